// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register-file write port: port A (in-order pipe) has priority,
// port B (long-latency results) is queued in a FIFO, and a pending bitmap tracks B writes not yet in the BRAM.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         a_we,
    input  logic [ADDR_WIDTH-1:0]        a_addr,
    input  logic [DATA_WIDTH-1:0]        a_data,
    input  logic                         b_valid,
    output logic                         b_ready,
    input  logic [ADDR_WIDTH-1:0]        b_addr,
    input  logic [DATA_WIDTH-1:0]        b_data,
    output logic                         we3,
    output logic [ADDR_WIDTH-1:0]        a3,
    output logic [DATA_WIDTH-1:0]        rd3,
    output logic [(2**ADDR_WIDTH)-1:0]   pending,
    output logic [$clog2(DEPTH):0]       fifo_count
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 2**ADDR_WIDTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] fifo_addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_d [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  we3_q, we3_d;
    logic [ADDR_WIDTH-1:0] a3_q, a3_d;
    logic [DATA_WIDTH-1:0] rd3_q, rd3_d;
    logic                  src_b_q, src_b_d;
    logic [NREG-1:0]       pending_q, pending_d;

    logic                  a_eff_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  b_ready_s;
    logic [PW-1:0]         slot_off_s;
    logic                  slot_valid_s;

    // Accept is gated only by occupancy, so a same-cycle pop never frees a full FIFO.
    assign b_ready_s = (count_q != FULL_CNT);

    // Arbitration, FIFO update and writeback-register next state.
    always_comb begin
        a_eff_s = a_we && (a_addr != '0);
        pop_s   = !a_eff_s && (count_q != '0);
        push_s  = b_valid && b_ready_s && (b_addr != '0);

        we3_d   = 1'b0;
        a3_d    = a3_q;
        rd3_d   = rd3_q;
        src_b_d = src_b_q;
        if (a_eff_s) begin
            we3_d   = 1'b1;
            a3_d    = a_addr;
            rd3_d   = a_data;
            src_b_d = 1'b0;
        end else if (pop_s) begin
            we3_d   = 1'b1;
            a3_d    = fifo_addr_q[rd_ptr_q];
            rd3_d   = fifo_data_q[rd_ptr_q];
            src_b_d = 1'b1;
        end else begin
            we3_d   = 1'b0;
        end

        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        if (push_s) begin
            fifo_addr_d[wr_ptr_q] = b_addr;
            fifo_data_d[wr_ptr_q] = b_data;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d              = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Scoreboard is computed from next state so the registered bitmap matches the FIFO/we3 it describes.
    always_comb begin
        pending_d    = '0;
        slot_off_s   = '0;
        slot_valid_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off_s   = PW'(i) - rd_ptr_d;
            slot_valid_s = ({1'b0, slot_off_s} < count_d);
            pending_d[fifo_addr_d[i]] = pending_d[fifo_addr_d[i]] | slot_valid_s;
        end
        pending_d[a3_d] = pending_d[a3_d] | (we3_d && src_b_d);
        pending_d[0]    = 1'b0;
    end

    // State registers; reset discards queued entries and clears all outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            we3_q     <= 1'b0;
            a3_q      <= '0;
            rd3_q     <= '0;
            src_b_q   <= 1'b0;
            pending_q <= '0;
        end else begin
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            we3_q       <= we3_d;
            a3_q        <= a3_d;
            rd3_q       <= rd3_d;
            src_b_q     <= src_b_d;
            pending_q   <= pending_d;
        end
    end

    assign b_ready    = b_ready_s;
    assign we3        = we3_q;
    assign a3         = a3_q;
    assign rd3        = rd3_q;
    assign pending    = pending_q;
    assign fifo_count = count_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writeback stage directly upstream of the BRAM register file; drives its single write port (we3/a3/rd3).
- Merges two producers:
  - Port A: the in-order integer pipeline. Fixed priority, no backpressure.
  - Port B: long-latency results (load/FPU), valid/ready handshake, buffered in a small FIFO.
- Drops writes to x0.
- Exports a pending-write scoreboard so decode can stall on registers whose B result has not yet reached the BRAM.

Parameters:
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers)
- DEPTH, 4, port-B FIFO entries (power of two, >=2)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- a_we  input  1  port A write request, this cycle only
- a_addr  input  ADDR_WIDTH  port A destination register
- a_data  input  DATA_WIDTH  port A write data
- b_valid  input  1  port B result valid
- b_ready  output  1  port B accept; = !full, combinational from state only
- b_addr  input  ADDR_WIDTH  port B destination register
- b_data  input  DATA_WIDTH  port B write data
- we3  output  1  regfile write enable (registered)
- a3  output  ADDR_WIDTH  regfile write address (registered)
- rd3  output  DATA_WIDTH  regfile write data (registered)
- pending  output  2**ADDR_WIDTH  per-register "B write outstanding" bitmap
- fifo_count  output  clog2(DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset: rst low clears everything asynchronously, including mid-operation.
  - Outputs: we3=0, a3=0, rd3=0, pending=0, fifo_count=0, b_ready=1.
  - Queued entries are discarded.
- Port A is effective when a_we=1 and a_addr!=0. a_we with a_addr==0 is a no-op.
- Output select each cycle, registered into we3/a3/rd3 at the next edge (latency 1):
  - If A is effective: we3<=1, a3<=a_addr, rd3<=a_data. FIFO does not pop.
  - Else if FIFO is not empty: pop head; we3<=1, a3/rd3 <= head contents; output source flag <= B.
  - Else: we3<=0, a3/rd3 hold their values.
- Port B push occurs when b_valid && b_ready.
  - b_addr==0: accepted (handshake completes) but not enqueued.
  - No bypass around the FIFO. An entry accepted at edge N reaches we3 at edge N+1 at the earliest.
- Full / empty boundaries:
  - Full: b_ready=0 even if a pop occurs in the same cycle (no pass-through).
  - Empty: no pop. Push and pop in the same cycle are allowed when not full; fifo_count is unchanged.
- B starvation: when A is effective every cycle, B waits indefinitely. The upstream pipeline guarantees bubbles.
- Pointers: wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- Scoreboard:
  - pending[r] = OR over valid FIFO entries with addr==r, OR (we3 && source flag==B && a3==r).
  - It clears only after the cycle in which the BRAM write is performed.
  - pending[0] is always 0.
- WAW ordering:
  - Decode never issues an A write, or a new B op, to a register whose pending bit is set.
  - The bench asserts this. On violation, arbiter output order is A-first, then FIFO order, with no squashing.
- B entries leave in acceptance order.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release -> we3=0, b_ready=1, pending=0, fifo_count=0 for 5 cycles.
- A-only writes: a_we=1, a_addr=3, a_data=0xDEADBEEF -> next edge we3=1, a3=3, rd3=0xDEADBEEF. a_addr=0 -> we3=0.
- B through FIFO: push (7, 0x11) with no A activity -> pending[7]=1 after accept edge; we3=1, a3=7, rd3=0x11 one edge later; pending[7]=0 the cycle after we3 drops.
- Priority and full:
  - Push 4 B entries (regs 1..4) while A writes every cycle -> fifo_count=4, b_ready=0, pending[4:1]=4'b1111, B sees no writes.
  - Drop A -> writes to regs 1,2,3,4 in order on consecutive cycles.
  - b_ready returns to 1 one cycle after the first pop.
- Simultaneous push/pop and wrap: keep 2 entries queued while pushing one and popping one per cycle for 10 cycles -> fifo_count stays 2, order preserved across pointer wrap.
- Mid-operation reset and x0 drop:
  - B push to reg 0 -> handshake completes, fifo_count unchanged.
  - Assert rst with 3 entries queued -> we3, pending and fifo_count go to 0 before the next clock edge.
